xilly_stream_initiator: RTL and testbench



---
 rtl/xilly_stream_initiator_pkg.sv | 41 ++++
 rtl/xilly_stream_initiator_if.sv | 31 +++
 rtl/xilly_pattern_gen.sv | 32 +++
 rtl/xilly_stream_initiator.sv | 150 +++++++++++++++
 tb/tb_xilly_stream_initiator.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xilly_stream_initiator_pkg.sv
// rtl/xilly_stream_initiator_pkg.sv - shared types and helpers for the stream initiator
// Purpose: FSM state encoding, 32-bit stream word type, half-word split and sum helpers,
//          and the counting-pattern word builder.
// Ports:   none (package)
package xilly_stream_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef logic [31:0] stream_word_t;

    // [15:0] carries the first sample, [31:16] the second
    typedef struct packed {
        logic [15:0] second;
        logic [15:0] first;
    } half_pair_t;

    function automatic half_pair_t split_halves(input stream_word_t w);
        half_pair_t h;
        h.first  = w[15:0];
        h.second = w[31:16];
        return h;
    endfunction

    function automatic logic [31:0] half_sum(input stream_word_t w);
        half_pair_t h;
        h = split_halves(w);
        return {16'd0, h.first} + {16'd0, h.second};
    endfunction

    // even sample in the low half, the next odd sample in the high half
    function automatic stream_word_t pattern_word(input logic [15:0] even);
        return {even | 16'd1, even};
    endfunction

endpackage

// File: rtl/xilly_stream_initiator_if.sv
// rtl/xilly_stream_initiator_if.sv - write/read FIFO stream bundle towards the user block
// Purpose: groups the 32-bit write port (open/wren/data/full) and read port
//          (open/rden/data/empty) of the user block.
// Ports:   master modport = initiator side, slave modport = user block side.
interface xilly_stream_initiator_if;
    import xilly_stream_initiator_pkg::*;

    logic         wr_open;
    logic         wr_wren;
    stream_word_t wr_data;
    logic         wr_full;
    logic         rd_open;
    logic         rd_rden;
    stream_word_t rd_data;
    logic         rd_empty;

    modport master (
        output wr_open, wr_wren, wr_data,
        input  wr_full,
        output rd_open, rd_rden,
        input  rd_data, rd_empty
    );

    modport slave (
        input  wr_open, wr_wren, wr_data,
        output wr_full,
        input  rd_open, rd_rden,
        output rd_data, rd_empty
    );

endinterface

// File: rtl/xilly_pattern_gen.sv
// rtl/xilly_pattern_gen.sv - counting sample pattern source for the write stream
// Purpose: word counter k and pattern word {16'(2k+1), 16'(2k)}; k advances on each accepted write.
// Ports:   clk, rst_n (sync active-low), clear (restart at k=0), advance (write accepted),
//          count (k = words written), data (pattern word for k).
module xilly_pattern_gen
    import xilly_stream_initiator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output stream_word_t     data
);

    logic [15:0] even;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    // 2k truncated to 16 bits; the pattern wraps per half-word like the sample stream
    assign even = 16'({count, 1'b0});
    assign data = pattern_word(even);

endmodule

// File: rtl/xilly_stream_initiator.sv
// rtl/xilly_stream_initiator.sv - host-side self-test initiator for 32-bit FIFO streams
// Purpose: opens both streams, writes word_count pattern words, reads word_count words back,
//          and reports counts, a half-word checksum and abort/timeout status.
// Ports:   bus_clk, bus_rst_n (sync active-low); start/word_count/quiesce control;
//          strm (master side of the write/read streams);
//          busy, done, error, words_written, words_read, checksum status.
module xilly_stream_initiator
    import xilly_stream_initiator_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int OPEN_DELAY = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      bus_clk,
    input  logic                      bus_rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          word_count,
    input  logic                      quiesce,
    xilly_stream_initiator_if.master  strm,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CNT_W-1:0]          words_written,
    output logic [CNT_W-1:0]          words_read,
    output logic [31:0]               checksum
);

    localparam int OD_W = $clog2(OPEN_DELAY + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int OD_LAST = OPEN_DELAY - 1;
    localparam int TO_LAST = TIMEOUT - 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] reads_issued;
    logic [CNT_W-1:0] words_read_q;
    logic [31:0]      checksum_q;
    logic [OD_W-1:0]  open_cnt;
    logic [TO_W-1:0]  idle_cnt;
    logic             capture_q;
    logic             error_q;

    logic             busy_w;
    logic             launch;
    logic             abort;
    logic             wren;
    logic             rden;
    logic             capture;
    logic             timed_out;
    stream_word_t     pat_data;

    assign busy_w  = (state_q == ST_OPEN) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign launch  = (state_q == ST_IDLE) && start && !quiesce;
    assign abort   = busy_w && quiesce;

    assign wren = (state_q == ST_RUN) && !strm.wr_full && (words_written < count_q);
    assign rden = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !strm.rd_empty
                  && (reads_issued < count_q);

    // rd_data is valid the cycle after rden; a capture landing on the abort cycle is dropped
    assign capture   = capture_q && !abort;
    assign timed_out = (state_q == ST_DRAIN) && !capture && (idle_cnt == TO_W'(TO_LAST));

    xilly_pattern_gen #(
        .CNT_W(CNT_W)
    ) u_pattern_gen (
        .clk    (bus_clk),
        .rst_n  (bus_rst_n),
        .clear  (launch),
        .advance(wren),
        .count  (words_written),
        .data   (pat_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) state_d = ST_OPEN;
            end
            ST_OPEN: begin
                if (open_cnt == OD_W'(OD_LAST)) begin
                    state_d = (count_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (words_written == count_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (words_read_q == count_q || timed_out) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_DONE;
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            reads_issued <= '0;
            words_read_q <= '0;
            checksum_q   <= '0;
            open_cnt     <= '0;
            idle_cnt     <= '0;
            capture_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                count_q      <= word_count;
                reads_issued <= '0;
                words_read_q <= '0;
                checksum_q   <= '0;
                open_cnt     <= '0;
                idle_cnt     <= '0;
                capture_q    <= 1'b0;
                error_q      <= 1'b0;
            end else begin
                open_cnt  <= (state_q == ST_OPEN) ? open_cnt + 1'b1 : '0;
                capture_q <= rden && !abort;
                if (rden) reads_issued <= reads_issued + 1'b1;
                if (capture) begin
                    words_read_q <= words_read_q + 1'b1;
                    checksum_q   <= checksum_q + half_sum(strm.rd_data);
                end
                // idle counter only runs in DRAIN and restarts on every captured word
                if (state_q == ST_DRAIN && !capture) idle_cnt <= idle_cnt + 1'b1;
                else                                 idle_cnt <= '0;
                if (abort || timed_out) error_q <= 1'b1;
            end
        end
    end

    assign strm.wr_open = busy_w;
    assign strm.rd_open = busy_w;
    assign strm.wr_wren = wren;
    assign strm.wr_data = wren ? pat_data : '0;
    assign strm.rd_rden = rden;

    assign busy       = busy_w;
    assign done       = (state_q == ST_DONE);
    assign error      = error_q;
    assign words_read = words_read_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_xilly_stream_initiator.sv
// tb/tb_xilly_stream_initiator.sv - self-checking bench for xilly_stream_initiator
// Purpose: loopback FIFO user-block stub, write-pattern scoreboard and scenario tasks.
// Ports:   none (top-level bench)
module tb_xilly_stream_initiator;
    import xilly_stream_initiator_pkg::*;

    localparam int CNT_W      = 16;
    localparam int OPEN_DELAY = 10;
    localparam int TIMEOUT    = 1024;

    logic             bus_clk = 1'b0;
    logic             bus_rst_n;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             quiesce;
    logic             busy, done, error;
    logic [CNT_W-1:0] words_written, words_read;
    logic [31:0]      checksum;

    xilly_stream_initiator_if strm();

    xilly_stream_initiator #(
        .CNT_W(CNT_W), .OPEN_DELAY(OPEN_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .bus_clk      (bus_clk),
        .bus_rst_n    (bus_rst_n),
        .start        (start),
        .word_count   (word_count),
        .quiesce      (quiesce),
        .strm         (strm),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written),
        .words_read   (words_read),
        .checksum     (checksum)
    );

    always #5 bus_clk = ~bus_clk;

    // loopback user-block stub: non-FWFT FIFO, full and empty-limit change only on posedge
    logic [31:0] mem [0:4095];
    int          wp = 0, rp = 0, rd_cnt = 0;
    logic        flush = 1'b0, full_req = 1'b0, limit_en = 1'b0;
    int          limit = 0;

    always @(posedge bus_clk) begin
        strm.wr_full <= full_req;
        if (flush) begin
            wp <= 0; rp <= 0; rd_cnt <= 0;
        end else begin
            if (strm.wr_wren) begin
                mem[wp[11:0]] <= strm.wr_data;
                wp <= wp + 1;
            end
            if (strm.rd_rden) begin
                strm.rd_data <= mem[rp[11:0]];
                rp <= rp + 1;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end
    assign strm.rd_empty = (wp == rp) || (limit_en && rd_cnt >= limit);

    int          n_total = 0, n_pass = 0;
    int          cyc = 0, done_cnt = 0, strobe_cnt = 0, open_cyc = 0, wr_ev = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    function automatic logic [31:0] tb_pattern(input int k);
        logic [15:0] lo, hi;
        lo = 16'(2 * k);
        hi = 16'(2 * k + 1);
        return {hi, lo};
    endfunction

    function automatic logic [31:0] tb_sum(input int n);
        logic [31:0] s = 0;
        for (int k = 0; k < n; k++) s += 32'(16'(2 * k)) + 32'(16'(2 * k + 1));
        return s;
    endfunction

    // one clock step; scoreboard and strobe monitoring on the falling edge
    task automatic tick();
        @(negedge bus_clk);
        cyc++;
        if (strm.wr_wren === 1'b1) begin
            wr_ev++;
            n_total++;
            if (strm.wr_full !== 1'b0) $display("FAIL wren_while_full cyc=%0d full=%b required 0", cyc, strm.wr_full);
            else n_pass++;
            n_total++;
            if (exp_q.size() == 0) $display("FAIL wr_extra cyc=%0d data=%h required no write", cyc, strm.wr_data);
            else begin
                exp_w = exp_q.pop_front();
                if (strm.wr_data !== exp_w) $display("FAIL wr_data cyc=%0d got %h required %h", cyc, strm.wr_data, exp_w);
                else n_pass++;
            end
        end
        if (strm.rd_rden === 1'b1) begin
            n_total++;
            if (strm.rd_empty !== 1'b0) $display("FAIL rden_while_empty cyc=%0d empty=%b required 0", cyc, strm.rd_empty);
            else n_pass++;
        end
        if (done === 1'b1) done_cnt++;
        if (strm.wr_wren === 1'b1 || strm.rd_rden === 1'b1) strobe_cnt++;
        if (strm.wr_open === 1'b1) open_cyc++;
    endtask

    task automatic prep(input int n, input logic lim_en, input int lim);
        flush = 1'b1; full_req = 1'b0;
        tick();
        flush = 1'b0;
        limit_en = lim_en; limit = lim;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(tb_pattern(k));
    endtask

    task automatic launch(input int n);
        word_count = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int elapsed);
        int d0 = done_cnt;
        elapsed = 0;
        while (done_cnt == d0 && elapsed < bound) begin
            tick();
            elapsed++;
        end
        n_total++;
        if (done_cnt == d0) $display("FAIL %s_done_timeout got no done in %0d cycles required done", name, bound);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || done_cnt != d0 + 1) $display("FAIL %s_done_pulse done=%b pulses=%0d required 0/1", name, done, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic check_results(input string name, input int n_w, input int n_r, input logic err);
        n_total++;
        if (words_written !== CNT_W'(n_w)) $display("FAIL %s_words_written got %0d required %0d", name, words_written, n_w);
        else n_pass++;
        n_total++;
        if (words_read !== CNT_W'(n_r)) $display("FAIL %s_words_read got %0d required %0d", name, words_read, n_r);
        else n_pass++;
        n_total++;
        if (checksum !== tb_sum(n_r)) $display("FAIL %s_checksum got %0d required %0d", name, checksum, tb_sum(n_r));
        else n_pass++;
        n_total++;
        if (error !== err) $display("FAIL %s_error got %b required %b", name, error, err);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus_rst_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({strm.wr_open, strm.rd_open, strm.wr_wren, strm.rd_rden, strm.wr_data, busy, done, error,
             words_written, words_read, checksum} !== '0)
            $display("FAIL reset_outputs got nonzero (busy=%b wr_data=%h ww=%0d) required all 0", busy, strm.wr_data, words_written);
        else n_pass++;
        bus_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        int el;
        prep(512, 1'b0, 0);
        launch(512);
        wait_done("loopback", 5000, el);
        check_results("loopback", 512, 512, 1'b0);
        n_total++;
        if (checksum !== 32'd523776) $display("FAIL loopback_checksum_const got %0d required 523776", checksum);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL loopback_missing_writes got %0d left required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_full_window();
        int el, i, ev0;
        prep(512, 1'b0, 0);
        launch(512);
        ev0 = wr_ev; i = 0;
        while (wr_ev == ev0 && i < 100) begin tick(); i++; end
        n_total++;
        if (wr_ev == ev0) $display("FAIL full_first_write got none required a write");
        else n_pass++;
        repeat (19) tick();
        full_req = 1'b1;
        ev0 = wr_ev;
        repeat (21) tick();
        full_req = 1'b0;
        n_total++;
        if (wr_ev != ev0) $display("FAIL full_window_writes got %0d required 0", wr_ev - ev0);
        else n_pass++;
        wait_done("full", 5000, el);
        check_results("full", 512, 512, 1'b0);
    endtask

    task automatic test_timeout();
        int el;
        prep(200, 1'b1, 100);
        launch(200);
        wait_done("timeout", 4000, el);
        check_results("timeout", 200, 100, 1'b1);
        n_total++;
        if (el < TIMEOUT) $display("FAIL timeout_elapsed got %0d cycles required >= %0d", el, TIMEOUT);
        else n_pass++;
    endtask

    task automatic test_quiesce();
        int el, i;
        prep(512, 1'b0, 0);
        launch(512);
        i = 0;
        while (words_written != CNT_W'(37) && i < 500) begin tick(); i++; end
        quiesce = 1'b1;
        tick();
        n_total++;
        if ({strm.wr_wren, strm.rd_rden, strm.wr_open, strm.rd_open, busy} !== 5'b0)
            $display("FAIL quiesce_strobes got %b required 00000", {strm.wr_wren, strm.rd_rden, strm.wr_open, strm.rd_open, busy});
        else n_pass++;
        n_total++;
        if ({error, done} !== 2'b11) $display("FAIL quiesce_error_done got %b required 11", {error, done});
        else n_pass++;
        quiesce = 1'b0;
        tick();
        n_total++;
        if ({busy, done, error} !== 3'b001) $display("FAIL quiesce_idle got %b required 001", {busy, done, error});
        else n_pass++;
        prep(64, 1'b0, 0);
        launch(64);
        wait_done("after_quiesce", 2000, el);
        check_results("after_quiesce", 64, 64, 1'b0);
    endtask

    task automatic test_zero_count();
        int el, s0, o0;
        prep(0, 1'b0, 0);
        s0 = strobe_cnt; o0 = open_cyc;
        launch(0);
        wait_done("zero", 200, el);
        n_total++;
        if (open_cyc - o0 != OPEN_DELAY) $display("FAIL zero_open_cycles got %0d required %0d", open_cyc - o0, OPEN_DELAY);
        else n_pass++;
        n_total++;
        if (strobe_cnt != s0) $display("FAIL zero_strobes got %0d required 0", strobe_cnt - s0);
        else n_pass++;
        check_results("zero", 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        int el;
        prep(512, 1'b0, 0);
        launch(512);
        repeat (50) tick();
        word_count = CNT_W'(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart", 5000, el);
        check_results("restart", 512, 512, 1'b0);
    endtask

    task automatic test_reset_drain();
        int i;
        prep(200, 1'b1, 100);
        launch(200);
        i = 0;
        while (words_written != CNT_W'(200) && i < 1000) begin tick(); i++; end
        repeat (50) tick();
        n_total++;
        if (busy !== 1'b1) $display("FAIL drain_busy got %b required 1", busy);
        else n_pass++;
        bus_rst_n = 1'b0;
        tick();
        n_total++;
        if ({strm.wr_open, strm.rd_open, strm.wr_wren, strm.rd_rden, strm.wr_data, busy, done, error,
             words_written, words_read, checksum} !== '0)
            $display("FAIL drain_reset_outputs got nonzero (busy=%b ww=%0d wr=%0d) required all 0", busy, words_written, words_read);
        else n_pass++;
        bus_rst_n = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL drain_reset_idle busy=%b required 0", busy);
        else n_pass++;
    endtask

    initial begin
        start = 1'b0; quiesce = 1'b0; word_count = '0; bus_rst_n = 1'b0;
        test_reset();
        test_loopback();
        test_full_window();
        test_timeout();
        test_quiesce();
        test_zero_count();
        test_start_ignored();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
